// File: rtl/maze_nav_ctl_if.sv
// Sensor, motor-driver and decision-log signals of the maze navigation controller.
// The master side drives sensors/button/log pops; the slave side is the controller.
interface maze_nav_ctl_if #(
    parameter int N_CH  = 8,
    parameter int DEPTH = 64
);
    logic [N_CH-1:0]         ir_color;
    logic                    bump;
    logic                    WF_BUTTON;
    logic                    hand_sel;
    logic                    step_done;
    logic                    driver_sel;
    logic                    speedctl_en;
    logic                    stepctl_en;
    logic                    motorL_dir;
    logic                    motorR_dir;
    logic [15:0]             speedL;
    logic [15:0]             speedR;
    logic [15:0]             degreeL;
    logic [15:0]             degreeR;
    logic                    goal;
    logic                    log_rd_en;
    logic [1:0]              log_data;
    logic                    log_empty;
    logic [$clog2(DEPTH):0]  log_count;
    logic                    log_ovf;

    modport master (
        output ir_color, bump, WF_BUTTON, hand_sel, step_done, log_rd_en,
        input  driver_sel, speedctl_en, stepctl_en, motorL_dir, motorR_dir,
        input  speedL, speedR, degreeL, degreeR, goal,
        input  log_data, log_empty, log_count, log_ovf
    );

    modport slave (
        input  ir_color, bump, WF_BUTTON, hand_sel, step_done, log_rd_en,
        output driver_sel, speedctl_en, stepctl_en, motorL_dir, motorR_dir,
        output speedL, speedR, degreeL, degreeR, goal,
        output log_data, log_empty, log_count, log_ovf
    );
endinterface

// File: rtl/maze_nav_ctl.sv
// Wall-following maze controller: debounced IR patterns drive the FSM, junction
// decisions are logged in a small circular FIFO for later path replay.
//   state        | meaning
//   S_IDLE       | after reset, motors stopped
//   S_WAIT       | stopped, waiting for start button
//   S_SEARCH     | driving forward looking for the line
//   S_FOLLOW     | following the line, evaluating junctions
//   S_CORRECT    | pivoting back onto the line
//   S_TURN       | one-cycle left/right step command
//   S_UTURN      | one-cycle U-turn step command
//   S_STEP_WAIT  | waiting for stepctl to finish
//   S_UTURN_SEEK | reversing until the line is lost again
//   S_DONE       | goal reached, stopped
module maze_nav_ctl #(
    parameter int N_CH      = 8,
    parameter int DB_CYC    = 1600000,
    parameter int DEPTH     = 64,
    parameter int FWD_SPD   = 360,
    parameter int FOL_SPD   = 180,
    parameter int TURN_OUT  = 240,
    parameter int TURN_IN   = 120,
    parameter int UTURN_DEG = 360
) (
    input logic          WF_CLK,
    input logic          rst,
    maze_nav_ctl_if.slave io
);
    localparam int H   = N_CH / 2;
    localparam int SW  = $clog2(H) + 1;
    localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [15:0] FWD_V = 16'(FWD_SPD);
    localparam logic [15:0] FOL_V = 16'(FOL_SPD);
    localparam logic [15:0] OUT_V = 16'(TURN_OUT);
    localparam logic [15:0] IN_V  = 16'(TURN_IN);
    localparam logic [15:0] UT_V  = 16'(UTURN_DEG);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_SEARCH, S_FOLLOW, S_CORRECT,
        S_TURN, S_UTURN, S_STEP_WAIT, S_UTURN_SEEK, S_DONE
    } state_t;

    logic right_raw, left_raw, lost_raw, goal_raw, on_raw, pos_ok_raw;
    logic [SW-1:0] lsum, rsum;

    assign right_raw = &io.ir_color[H-1:0];
    assign left_raw  = &io.ir_color[N_CH-1:H];
    assign lost_raw  = ~|io.ir_color;
    assign goal_raw  = &io.ir_color;
    assign on_raw    = io.ir_color[H-1] | io.ir_color[H];

    always_comb begin
        pos_ok_raw = on_raw;
        lsum       = '0;
        rsum       = '0;
        for (int k = 0; k < H; k++) begin
            if (io.ir_color[H+k] != io.ir_color[H-1-k]) pos_ok_raw = 1'b0;
            lsum = lsum + SW'(io.ir_color[H+k]);
            rsum = rsum + SW'(io.ir_color[k]);
        end
    end

    // Bit order: 0 on_track, 1 lost, 2 pos_ok, 3 goal_f; down-counter per bit.
    logic [3:0]     flt_raw, flt_q;
    logic [DBW-1:0] db_cnt_q [4];
    logic           on_track, lost, pos_ok, goal_f;

    assign flt_raw  = {goal_raw, pos_ok_raw, lost_raw, on_raw};
    assign on_track = flt_q[0];
    assign lost     = flt_q[1];
    assign pos_ok   = flt_q[2];
    assign goal_f   = flt_q[3];

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            flt_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= DBW'(DB_CYC - 1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (flt_raw[i] == flt_q[i]) begin
                    db_cnt_q[i] <= DBW'(DB_CYC - 1);
                end else if (db_cnt_q[i] == '0) begin
                    flt_q[i]    <= flt_raw[i];
                    db_cnt_q[i] <= DBW'(DB_CYC - 1);
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] - 1'b1;
                end
            end
        end
    end

    state_t      state_q, state_d, ret_q, ret_d;
    logic        hand_q, hand_d, sw_first_q, jr_q, jl_q, goal_q;
    logic        pref_j, opp_j, opp_j_q, push;
    logic [1:0]  push_code;
    logic        drv_q, drv_d, sen_q, sen_d, pen_q, pen_d, dl_q, dl_d, dr_q, dr_d;
    logic [15:0] sl_q, sl_d, sr_q, sr_d, dgl_q, dgl_d, dgr_q, dgr_d;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        hand_d    = hand_q;
        push      = 1'b0;
        push_code = 2'd0;
        pref_j    = hand_q ? left_raw : right_raw;
        opp_j     = hand_q ? right_raw : left_raw;
        opp_j_q   = hand_q ? jr_q : jl_q;
        case (state_q)
            S_WAIT: if (!io.WF_BUTTON) begin
                hand_d  = io.hand_sel;
                state_d = S_SEARCH;
            end
            S_SEARCH: if (on_track) state_d = S_FOLLOW;
            S_FOLLOW: begin
                if (goal_f) begin
                    state_d = S_DONE;
                end else if (pref_j) begin
                    state_d   = S_TURN;
                    push      = 1'b1;
                    push_code = hand_q ? 2'd2 : 2'd1;
                end else if (opp_j) begin
                    push = !opp_j_q;
                end else if (pos_ok) begin
                    state_d = S_FOLLOW;
                end else if (!lost) begin
                    state_d = S_CORRECT;
                end else begin
                    state_d   = S_UTURN;
                    push      = 1'b1;
                    push_code = 2'd3;
                end
            end
            S_CORRECT: if (lsum == rsum) state_d = S_FOLLOW;
            S_TURN: begin
                state_d = S_STEP_WAIT;
                ret_d   = S_FOLLOW;
            end
            S_UTURN: begin
                state_d = S_STEP_WAIT;
                ret_d   = S_UTURN_SEEK;
            end
            S_STEP_WAIT: if (io.step_done && !sw_first_q) state_d = ret_q;
            S_UTURN_SEEK: if (lost) state_d = S_SEARCH;
            S_IDLE, S_DONE: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
        if (!io.bump) begin
            state_d = S_WAIT;
            hand_d  = hand_q;
            push    = 1'b0;
        end

        drv_d = 1'b0; sen_d = 1'b0; pen_d = 1'b0; dl_d = 1'b0; dr_d = 1'b0;
        sl_d  = '0;   sr_d  = '0;   dgl_d = '0;   dgr_d = '0;
        case (state_d)
            S_SEARCH: begin
                sen_d = 1'b1; sl_d = FWD_V; sr_d = FWD_V;
            end
            S_FOLLOW: begin
                sen_d = 1'b1; sl_d = FOL_V; sr_d = FOL_V;
            end
            S_CORRECT: begin
                sen_d = 1'b1; sl_d = FOL_V; sr_d = FOL_V;
                dl_d  = (lsum > rsum);
                dr_d  = !(lsum > rsum);
            end
            S_TURN: begin
                drv_d = 1'b1; pen_d = 1'b1;
                dgl_d = hand_q ? IN_V : OUT_V;
                dgr_d = hand_q ? OUT_V : IN_V;
                dl_d  = hand_q;
                dr_d  = !hand_q;
            end
            S_UTURN: begin
                drv_d = 1'b1; pen_d = 1'b1; dgl_d = UT_V; dgr_d = UT_V; dr_d = 1'b1;
            end
            S_STEP_WAIT: begin
                drv_d = 1'b1; dl_d = dl_q; dr_d = dr_q;
                sl_d  = sl_q; sr_d = sr_q; dgl_d = dgl_q; dgr_d = dgr_q;
            end
            S_UTURN_SEEK: begin
                sen_d = 1'b1; sl_d = FOL_V; sr_d = FOL_V; dl_d = 1'b1; dr_d = 1'b1;
            end
            default: drv_d = 1'b0;
        endcase
    end

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            state_q <= S_IDLE; ret_q <= S_FOLLOW; hand_q <= 1'b0; sw_first_q <= 1'b0;
            jr_q <= 1'b0; jl_q <= 1'b0; goal_q <= 1'b0;
            drv_q <= 1'b0; sen_q <= 1'b0; pen_q <= 1'b0; dl_q <= 1'b0; dr_q <= 1'b0;
            sl_q <= '0; sr_q <= '0; dgl_q <= '0; dgr_q <= '0;
        end else begin
            state_q <= state_d; ret_q <= ret_d; hand_q <= hand_d;
            sw_first_q <= (state_q == S_TURN) || (state_q == S_UTURN);
            jr_q <= right_raw; jl_q <= left_raw;
            goal_q <= goal_q | (state_d == S_DONE);
            drv_q <= drv_d; sen_q <= sen_d; pen_q <= pen_d; dl_q <= dl_d; dr_q <= dr_d;
            sl_q <= sl_d; sr_q <= sr_d; dgl_q <= dgl_d; dgr_q <= dgr_d;
        end
    end

    logic [1:0]    log_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q, full, empty, push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop_ok  = io.log_rd_en && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge WF_CLK) begin
        if (push_ok) log_mem[wr_ptr_q] <= push_code;
    end

    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0; ovf_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    assign io.driver_sel  = drv_q;
    assign io.speedctl_en = sen_q;
    assign io.stepctl_en  = pen_q;
    assign io.motorL_dir  = dl_q;
    assign io.motorR_dir  = dr_q;
    assign io.speedL      = sl_q;
    assign io.speedR      = sr_q;
    assign io.degreeL     = dgl_q;
    assign io.degreeR     = dgr_q;
    assign io.goal        = goal_q;
    assign io.log_data    = empty ? 2'd0 : log_mem[rd_ptr_q];
    assign io.log_empty   = empty;
    assign io.log_count   = cnt_q;
    assign io.log_ovf     = ovf_q;
endmodule

// File: tb/tb_maze_nav_ctl.sv
// Directed bench for maze_nav_ctl (N_CH=8, DB_CYC=4, DEPTH=4): cycle table for
// start-up and both turn directions, then hand sequences for the multi-cycle corners.
module tb_maze_nav_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maze_nav_ctl_if #(.N_CH(8), .DEPTH(4)) io ();

    maze_nav_ctl #(.N_CH(8), .DB_CYC(4), .DEPTH(4)) dut (
        .WF_CLK(clk),
        .rst   (rst),
        .io    (io)
    );

    typedef struct packed {
        logic drv; logic sen; logic pen; logic dl; logic dr;
        logic [15:0] sl; logic [15:0] sr; logic [15:0] dgl; logic [15:0] dgr;
    } mot_t;

    typedef struct packed {
        logic goal; logic [2:0] cnt; logic [1:0] dat; logic emp; logic ovf;
    } lg_t;

    typedef struct {
        logic [7:0] ir;
        logic bump; logic btn; logic hsel; logic sdone;
        mot_t em;
        lg_t  el;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;

    function automatic mot_t mot(logic drv, logic sen, logic pen, logic dl, logic dr,
                                 int sl, int sr, int dgl, int dgr);
        mot_t m;
        m.drv = drv; m.sen = sen; m.pen = pen; m.dl = dl; m.dr = dr;
        m.sl = 16'(sl); m.sr = 16'(sr); m.dgl = 16'(dgl); m.dgr = 16'(dgr);
        return m;
    endfunction

    function automatic lg_t lg(logic g, int cnt, int dat, logic ovf);
        lg_t l;
        l.goal = g; l.cnt = 3'(cnt); l.dat = 2'(dat); l.emp = (cnt == 0); l.ovf = ovf;
        return l;
    endfunction

    function automatic vec_t vv(logic [7:0] ir, logic bump, logic btn, logic hsel,
                                logic sdone, mot_t em, lg_t el);
        vec_t v;
        v.ir = ir; v.bump = bump; v.btn = btn; v.hsel = hsel; v.sdone = sdone;
        v.em = em; v.el = el;
        return v;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, mot_t em, lg_t el);
        mot_t mg;
        lg_t  lgot;
        mg   = mot(io.driver_sel, io.speedctl_en, io.stepctl_en, io.motorL_dir, io.motorR_dir,
                   int'(io.speedL), int'(io.speedR), int'(io.degreeL), int'(io.degreeR));
        lgot = '{goal: io.goal, cnt: io.log_count, dat: io.log_data, emp: io.log_empty, ovf: io.log_ovf};
        n_tot++;
        if (mg !== em) $display("FAIL %s motors got %h expected %h", nm, mg, em);
        else n_pass++;
        n_tot++;
        if (lgot !== el) $display("FAIL %s log got %h expected %h", nm, lgot, el);
        else n_pass++;
    endtask

    mot_t M_STOP, M_SRCH, M_FOL, M_TR, M_SWR, M_TL, M_SWL, M_UT, M_SWU, M_SEEK;
    vec_t vt[$];
    logic [1:0] codes [4];

    initial begin
        M_STOP = mot(0, 0, 0, 0, 0, 0, 0, 0, 0);
        M_SRCH = mot(0, 1, 0, 0, 0, 360, 360, 0, 0);
        M_FOL  = mot(0, 1, 0, 0, 0, 180, 180, 0, 0);
        M_TR   = mot(1, 0, 1, 0, 1, 0, 0, 240, 120);
        M_SWR  = mot(1, 0, 0, 0, 1, 0, 0, 240, 120);
        M_TL   = mot(1, 0, 1, 1, 0, 0, 0, 120, 240);
        M_SWL  = mot(1, 0, 0, 1, 0, 0, 0, 120, 240);
        M_UT   = mot(1, 0, 1, 0, 1, 0, 0, 360, 360);
        M_SWU  = mot(1, 0, 0, 0, 1, 0, 0, 360, 360);
        M_SEEK = mot(0, 1, 0, 1, 1, 180, 180, 0, 0);
        codes[0] = 2'd0; codes[1] = 2'd2; codes[2] = 2'd3; codes[3] = 2'd0;

        // start-up, right-hand junction, left-hand mode
        vt.push_back(vv(8'h00, 0, 1, 0, 0, M_STOP, lg(0, 0, 0, 0)));
        vt.push_back(vv(8'h00, 1, 1, 0, 0, M_STOP, lg(0, 0, 0, 0)));
        vt.push_back(vv(8'h00, 1, 0, 0, 0, M_SRCH, lg(0, 0, 0, 0)));
        for (int i = 0; i < 4; i++) vt.push_back(vv(8'h18, 1, 1, 0, 0, M_SRCH, lg(0, 0, 0, 0)));
        vt.push_back(vv(8'h18, 1, 1, 0, 0, M_FOL, lg(0, 0, 0, 0)));
        vt.push_back(vv(8'h18, 1, 1, 0, 0, M_FOL, lg(0, 0, 0, 0)));
        vt.push_back(vv(8'h1F, 1, 1, 0, 0, M_TR,  lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 0, 1, M_SWR, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 0, 1, M_SWR, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 0, 1, M_FOL, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 0, 0, M_FOL, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 0, 1, 0, 0, M_STOP, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 1, 0, M_STOP, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 1, 0, 1, 0, M_SRCH, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 1, 0, M_FOL, lg(0, 1, 1, 0)));
        vt.push_back(vv(8'h1F, 1, 1, 1, 0, M_FOL, lg(0, 2, 1, 0)));
        vt.push_back(vv(8'h1F, 1, 1, 1, 0, M_FOL, lg(0, 2, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 1, 0, M_FOL, lg(0, 2, 1, 0)));
        vt.push_back(vv(8'hF8, 1, 1, 1, 0, M_TL,  lg(0, 3, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 1, 1, M_SWL, lg(0, 3, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 1, 1, M_SWL, lg(0, 3, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 1, 1, M_FOL, lg(0, 3, 1, 0)));
        vt.push_back(vv(8'h18, 1, 1, 1, 0, M_FOL, lg(0, 3, 1, 0)));

        io.ir_color = 8'h00; io.bump = 1'b1; io.WF_BUTTON = 1'b1;
        io.hand_sel = 1'b0; io.step_done = 1'b0; io.log_rd_en = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("reset", M_STOP, lg(0, 0, 0, 0));
        rst = 1'b0;

        foreach (vt[i]) begin
            io.ir_color = vt[i].ir; io.bump = vt[i].bump; io.WF_BUTTON = vt[i].btn;
            io.hand_sel = vt[i].hsel; io.step_done = vt[i].sdone;
            tick(1);
            chk($sformatf("vec%0d", i), vt[i].em, vt[i].el);
        end

        // dead end: lost must debounce before the U-turn
        io.ir_color = 8'h00;
        tick(4);
        chk("deadend_hold", M_FOL, lg(0, 3, 1, 0));
        tick(1);
        chk("uturn", M_UT, lg(0, 4, 1, 0));
        io.ir_color = 8'h18;
        tick(1);
        chk("uturn_wait", M_SWU, lg(0, 4, 1, 0));
        tick(3);
        chk("uturn_wait_busy", M_SWU, lg(0, 4, 1, 0));
        io.step_done = 1'b1;
        tick(1);
        chk("seek", M_SEEK, lg(0, 4, 1, 0));
        io.step_done = 1'b0; io.ir_color = 8'h00;
        tick(4);
        chk("seek_hold", M_SEEK, lg(0, 4, 1, 0));
        tick(1);
        chk("seek_to_search", M_SRCH, lg(0, 4, 1, 0));

        // log boundaries
        io.ir_color = 8'h18;
        tick(5);
        chk("refollow", M_FOL, lg(0, 4, 1, 0));
        io.ir_color = 8'h1F;
        tick(1);
        chk("push_full", M_FOL, lg(0, 4, 1, 1));
        io.ir_color = 8'h18;
        tick(1);
        io.ir_color = 8'h1F; io.log_rd_en = 1'b1;
        tick(1);
        chk("pushpop_full", M_FOL, lg(0, 4, 0, 1));
        io.ir_color = 8'h18; io.log_rd_en = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), M_FOL, lg(0, 4 - i, codes[i], 1));
            io.log_rd_en = 1'b1;
            tick(1);
            io.log_rd_en = 1'b0;
        end
        chk("drained", M_FOL, lg(0, 0, 0, 1));
        io.log_rd_en = 1'b1;
        tick(1);
        chk("pop_empty", M_FOL, lg(0, 0, 0, 1));
        io.ir_color = 8'h1F;
        tick(1);
        chk("pushpop_empty", M_FOL, lg(0, 1, 0, 1));
        io.ir_color = 8'h18;
        tick(1);
        io.log_rd_en = 1'b0;
        chk("pop_last", M_FOL, lg(0, 0, 0, 1));

        // bump override during step wait, then goal
        io.ir_color = 8'hF8;
        tick(1);
        chk("turn_left2", M_TL, lg(0, 1, 2, 1));
        io.ir_color = 8'h18;
        tick(1);
        io.bump = 1'b0;
        tick(1);
        chk("bump_override", M_STOP, lg(0, 1, 2, 1));
        io.bump = 1'b1; io.ir_color = 8'hFF;
        tick(4);
        chk("wait_goal_seen", M_STOP, lg(0, 1, 2, 1));
        io.WF_BUTTON = 1'b0;
        tick(1);
        chk("restart", M_SRCH, lg(0, 1, 2, 1));
        io.WF_BUTTON = 1'b1;
        tick(1);
        chk("refollow2", M_FOL, lg(0, 1, 2, 1));
        tick(1);
        chk("goal", M_STOP, lg(1, 1, 2, 1));
        io.bump = 1'b0;
        tick(1);
        chk("goal_sticky", M_STOP, lg(1, 1, 2, 1));
        io.bump = 1'b1;
        rst = 1'b1;
        tick(1);
        chk("final_reset", M_STOP, lg(0, 0, 0, 0));
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/maze_nav_ctl.md
# maze_nav_ctl

Parametrised maze-navigation controller for the line-following robot. It sits between the IR threshold logic and the motor drivers (`speedctl` / `stepctl`). It generalises the fixed 8-channel right-turn-only controller to N sensor channels and a run-time selectable wall-following hand. It adds goal detection and a readable junction-decision log for later path replay.

## Interface

Parameters:
- `N_CH`, 8: IR channel count; even, ≥4.
- `DB_CYC`, 1600000: debounce length in cycles for the filtered pattern signals.
- `DEPTH`, 64: decision-log entries; power of two.
- `FWD_SPD`, 360: SEARCH speed (deg/s).
- `FOL_SPD`, 180: FOLLOW, CORRECT and UTURN_SEEK speed.
- `TURN_OUT`, 240: step degrees, outer wheel, L/R turn.
- `TURN_IN`, 120: step degrees, inner wheel, L/R turn.
- `UTURN_DEG`, 360: step degrees, both wheels, U-turn.

Ports:
- `WF_CLK` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `ir_color` in N_CH: 1 = black; bit 0 is the rightmost sensor.
- `bump` in 1: consolidated bumper, active-low (0 = hit).
- `WF_BUTTON` in 1: start button, active-low.
- `hand_sel` in 1: 0 = right-hand rule, 1 = left-hand rule.
- `step_done` in 1: both `stepctl` instances idle.
- `driver_sel` out 1: 0 = speedctl path, 1 = stepctl path.
- `speedctl_en` out 1: enable for the speed-controlled drivers.
- `stepctl_en` out 1: one-cycle start pulse to `stepctl`.
- `motorL_dir`, `motorR_dir` out 1 each: 0 = forward.
- `speedL`, `speedR` out 16 each: speed command.
- `degreeL`, `degreeR` out 16 each: step command, valid while `stepctl_en` is 1.
- `goal` out 1: sticky, set on goal reached.
- `log_rd_en` in 1: pop one log entry.
- `log_data` out 2: head entry. 0 = straight, 1 = right, 2 = left, 3 = U-turn.
- `log_empty` out 1: log holds no entries.
- `log_count` out $clog2(DEPTH)+1: number of entries.
- `log_ovf` out 1: sticky overflow flag.

## Operation

**Patterns.** Let H = N_CH/2.
- `right_raw`: `ir_color[H-1:0]` all 1.
- `left_raw`: `ir_color[N_CH-1:H]` all 1.
- `lost_raw`: all bits 0.
- `goal_raw`: all bits 1.
- `on_raw`: bit H-1 or bit H is 1.
- `pos_ok_raw`: `on_raw`, and bit H+k equals bit H-1-k for every k.
- `lsum` / `rsum`: popcount of the high half / low half.

**Debounce.** `on_track`, `lost`, `pos_ok` and `goal_f` are each filtered. The filtered value takes the raw value only after the raw value has differed from it for DB_CYC consecutive cycles. All filtered values reset to 0.

**States:**
- IDLE: outputs stopped. Leave on `bump`=0 → WAIT.
- WAIT: outputs stopped. On `WF_BUTTON`=0: latch `hand_sel` into `hand`, → SEARCH.
- SEARCH: forward at FWD_SPD. `on_track` → FOLLOW.
- FOLLOW: forward at FOL_SPD. Checks in priority order:
  1. `goal_f` → DONE.
  2. Junction on the preferred side (right when `hand`=0, left when `hand`=1) → TURN; push 1 or 2.
  3. Junction on the opposite side only → stay in FOLLOW; push 0 on that junction's rising edge.
  4. `pos_ok` → stay in FOLLOW.
  5. Not `lost` → CORRECT.
  6. `lost` → UTURN; push 3.
- CORRECT: pivot at FOL_SPD. If `lsum` > `rsum`, dirL=1 and dirR=0; otherwise the reverse. `lsum` == `rsum` → FOLLOW.
- TURN: one cycle. `driver_sel`=1, `stepctl_en`=1.
  - Right turn: degL=TURN_OUT, degR=TURN_IN, dirR=1.
  - Left turn: the mirror of right.
  - → STEP_WAIT, with return state FOLLOW.
- UTURN: one cycle. Both degrees = UTURN_DEG, dirL=0, dirR=1. → STEP_WAIT, with return state UTURN_SEEK.
- STEP_WAIT: `driver_sel`=1; directions and speeds held. `step_done` → return state.
- UTURN_SEEK: reverse at FOL_SPD. `lost` → SEARCH.
- DONE: stopped, `goal`=1. Leave only on reset or `bump`=0.

**Bump override.** `bump`=0 in any state forces WAIT on the next cycle. This takes priority over all other transitions, including one scheduled for the same cycle. The log, `log_ovf` and `goal` are retained.

**Decision log.**
- Circular FIFO, DEPTH × 2 bits.
- A push when full is dropped and sets `log_ovf`.
- A pop when empty is ignored.
- Push and pop in the same cycle: when full, both succeed; when empty, only the push takes effect.
- Pointers wrap modulo DEPTH.

## Timing

- All outputs are registered and reflect the current state. An input event at edge k changes the state at edge k+1; outputs change with the state.
- Reset values:
  - State IDLE; all motor outputs 0; `driver_sel` 0.
  - `stepctl_en` 0, `goal` 0.
  - Log empty: `log_count` 0, `log_empty` 1, `log_ovf` 0, `log_data` 0.
- A reset asserted mid-turn returns to IDLE on the next edge, even while `stepctl` is still busy.
- `stepctl_en` is high for exactly one cycle per TURN or UTURN.
- STEP_WAIT ignores `step_done` during its first cycle, because `stepctl` has not yet reported busy.
- `log_data` shows the head entry combinationally from RAM or registers. A pop advances the head at the next edge.
- `lsum` and `rsum` are $clog2(H)+1 bits wide.
- The debounce counter width is sized for DB_CYC.

## Test plan

1. **Start-up.** DB_CYC=4, N_CH=8. Reset, then `bump`=0 then 1, then `WF_BUTTON`=0. Expect WAIT→SEARCH with `speedL`=`speedR`=360. Hold `ir_color`=0x18 for 4 cycles → FOLLOW, speeds 180.
2. **Right-hand junction.** `hand`=0, `ir_color`=0x1F for 4+ cycles. Expect one `stepctl_en` pulse with degL=240, degR=120, dirR=1. Then `log_count`=1 and `log_data`=1. Raise `step_done` → FOLLOW.
3. **Left-hand mode.** Same stimulus as scenario 2 with `hand_sel`=1. Expect no turn and one push of 0. Then `ir_color`=0xF8 → left turn with degL=120, degR=240, dirL=1; push 2.
4. **Dead end.** `ir_color`=0x00 debounced in FOLLOW. Expect UTURN with degrees 360/360 and a push of 3. After `step_done`, UTURN_SEEK with both dirs=1. Once lost is re-confirmed → SEARCH.
5. **Log boundaries.** DEPTH=4. Make 5 pushes → `log_count`=4 and `log_ovf`=1, with the first four codes intact. Simultaneous pop and push while full → count stays 4. Pop to empty, then pop again → count stays 0.
6. **Override and goal.** `bump`=0 during STEP_WAIT → WAIT on the next edge; log kept. Hold `ir_color`=0xFF in FOLLOW → DONE, `goal`=1, motors 0. Reset → all outputs at reset values.
